// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for tlb_unit (INVTLB ops, page sizes, FSM, entry layout)
package tlb_pkg;
  localparam logic [4:0] INV_ALL0     = 5'd0;
  localparam logic [4:0] INV_ALL1     = 5'd1;
  localparam logic [4:0] INV_G        = 5'd2;
  localparam logic [4:0] INV_NG       = 5'd3;
  localparam logic [4:0] INV_ASID     = 5'd4;
  localparam logic [4:0] INV_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GASID_VA = 5'd6;
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_e;
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic        ps4m;
    logic [9:0]  asid;
    logic        g;
  } tlb_key_t;
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;
  typedef struct packed {
    tlb_key_t  key;
    tlb_page_t p0;
    tlb_page_t p1;
  } tlb_entry_t;
  typedef struct packed {
    logic      found;
    logic [5:0] ps;
    tlb_page_t pg;
  } tlb_rsp_t;
endpackage

// File: rtl/tlb_if.sv
// tlb_if: search/write/read/INVTLB signal bundle of tlb_unit
// TLB_PERF_CNT_EN adds the per-port hit/miss counters.
interface tlb_if #(parameter int IDX_W = 4);
  logic             s0_req, s1_req, s0_va_bit12, s1_va_bit12;
  logic [18:0]      s0_vppn, s1_vppn;
  logic [9:0]       s0_asid, s1_asid;
  logic             s0_rsp_valid, s1_rsp_valid, s0_found, s1_found;
  logic [IDX_W-1:0] s0_index, s1_index;
  logic [19:0]      s0_ppn, s1_ppn;
  logic [5:0]       s0_ps, s1_ps;
  logic [1:0]       s0_plv, s1_plv, s0_mat, s1_mat;
  logic             s0_d, s1_d, s0_v, s1_v;
  logic             we, w_fill, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IDX_W-1:0] w_index, r_index, fill_index;
  logic [18:0]      w_vppn, r_vppn, inv_vppn;
  logic [5:0]       w_ps, r_ps;
  logic [9:0]       w_asid, r_asid, inv_asid;
  logic [19:0]      w_ppn0, w_ppn1, r_ppn0, r_ppn1;
  logic [1:0]       w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
  logic             r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic             inv_req, inv_busy, inv_done, inv_err;
  logic [4:0]       inv_op;
`ifdef TLB_PERF_CNT_EN
  logic [31:0]      s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt;
`endif
  modport master (
    output s0_req, s1_req, s0_va_bit12, s1_va_bit12, s0_vppn, s1_vppn, s0_asid, s1_asid,
    input  s0_rsp_valid, s1_rsp_valid, s0_found, s1_found, s0_index, s1_index, s0_ppn, s1_ppn,
    input  s0_ps, s1_ps, s0_plv, s1_plv, s0_mat, s1_mat, s0_d, s1_d, s0_v, s1_v,
    output we, w_fill, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
    output w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    output r_index,
    input  r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
    input  r_ppn1, r_plv1, r_mat1, r_d1, r_v1, fill_index,
    output inv_req, inv_op, inv_asid, inv_vppn,
    input  inv_busy, inv_done, inv_err
`ifdef TLB_PERF_CNT_EN
    , input s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt
`endif
  );
  modport slave (
    input  s0_req, s1_req, s0_va_bit12, s1_va_bit12, s0_vppn, s1_vppn, s0_asid, s1_asid,
    output s0_rsp_valid, s1_rsp_valid, s0_found, s1_found, s0_index, s1_index, s0_ppn, s1_ppn,
    output s0_ps, s1_ps, s0_plv, s1_plv, s0_mat, s1_mat, s0_d, s1_d, s0_v, s1_v,
    input  we, w_fill, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
    input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    input  r_index,
    output r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
    output r_ppn1, r_plv1, r_mat1, r_d1, r_v1, fill_index,
    input  inv_req, inv_op, inv_asid, inv_vppn,
    output inv_busy, inv_done, inv_err
`ifdef TLB_PERF_CNT_EN
    , output s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt
`endif
  );
endinterface

// File: rtl/tlb_match.sv
// tlb_match: one-entry compare producing the search hit and the INVTLB clear decision
module tlb_match
  import tlb_pkg::*;
(
  input  tlb_key_t    entry,
  input  logic [18:0] vppn,
  input  logic [9:0]  asid,
  input  logic [4:0]  op,
  output logic        search_hit,
  output logic        inv_clr
);
  logic va_eq, asid_eq, g;
  assign g = entry.g;
  // a 4 MB page ignores vppn[8:0]; that bit range lives inside the page
  assign va_eq = entry.vppn[18:9] == vppn[18:9] && (entry.ps4m || entry.vppn[8:0] == vppn[8:0]);
  assign asid_eq = entry.asid == asid;
  assign search_hit = entry.e && va_eq && (asid_eq || g);
  assign inv_clr = entry.e && (op == INV_ALL0 || op == INV_ALL1 ||
                               (op == INV_G && g) ||
                               (op == INV_NG && !g) ||
                               (op == INV_ASID && !g && asid_eq) ||
                               (op == INV_ASID_VA && !g && asid_eq && va_eq) ||
                               (op == INV_GASID_VA && (g || asid_eq) && va_eq));
endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: parametrised fully-associative LoongArch TLB with registered dual search,
// fill-index hint and a multi-cycle INVTLB sweep; TLB_PERF_CNT_EN adds hit/miss counters.
module tlb_unit
  import tlb_pkg::*;
#(
  parameter int TLBNUM    = 16,
  parameter int INV_LANES = 4
) (
  input logic  clk,
  input logic  resetn,
  tlb_if.slave bus
);
  localparam int IDX_W = $clog2(TLBNUM);
  tlb_entry_t ent_q [TLBNUM];
  tlb_entry_t ent_d [TLBNUM];
  tlb_entry_t w_ent, r_ent;
  logic [TLBNUM-1:0] e_vec;
  logic [IDX_W-1:0] free_idx, rr_q, rr_d, ptr_q, ptr_d;
  inv_state_e state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [9:0] asid_q, asid_d;
  logic [18:0] vppn_q, vppn_d;
  logic err_q, err_d;
  logic [INV_LANES-1:0] lane_clr, lane_hit_unused;
  logic [INV_LANES-1:0][IDX_W-1:0] lane_idx;
  logic [1:0] s_req, s_bit12, valid_q, valid_d;
  logic [1:0][18:0] s_vppn;
  logic [1:0][9:0] s_asid;
  logic [1:0][IDX_W-1:0] idx_q, idx_d;
  tlb_rsp_t [1:0] rsp_q, rsp_d;
  assign s_req = {bus.s1_req, bus.s0_req};
  assign s_bit12 = {bus.s1_va_bit12, bus.s0_va_bit12};
  assign s_vppn = {bus.s1_vppn, bus.s0_vppn};
  assign s_asid = {bus.s1_asid, bus.s0_asid};
  assign w_ent = '{key: '{e: bus.w_e, vppn: bus.w_vppn, ps4m: bus.w_ps == PS_4M, asid: bus.w_asid, g: bus.w_g},
                   p0: '{ppn: bus.w_ppn0, plv: bus.w_plv0, mat: bus.w_mat0, d: bus.w_d0, v: bus.w_v0},
                   p1: '{ppn: bus.w_ppn1, plv: bus.w_plv1, mat: bus.w_mat1, d: bus.w_d1, v: bus.w_v1}};
  for (genvar i = 0; i < TLBNUM; i++) begin : g_e
    assign e_vec[i] = ent_q[i].key.e;
  end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TLBNUM-1:0] hit, clr_unused;
    logic [IDX_W-1:0] sel;
    logic odd;
    for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
      tlb_match u_match (.entry(ent_q[i].key), .vppn(s_vppn[p]), .asid(s_asid[p]), .op(INV_ALL0),
                         .search_hit(hit[i]), .inv_clr(clr_unused[i]));
    end
    always_comb begin
      sel = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) sel = hit[i] ? IDX_W'(i) : sel;
    end
    assign odd = ent_q[sel].key.ps4m ? s_vppn[p][8] : s_bit12[p];
    assign valid_d[p] = s_req[p];
    assign idx_d[p] = s_req[p] ? sel : idx_q[p];
    assign rsp_d[p] = !s_req[p] ? rsp_q[p] : !(|hit) ? '0 :
                      tlb_rsp_t'{1'b1, ent_q[sel].key.ps4m ? PS_4M : PS_4K, odd ? ent_q[sel].p1 : ent_q[sel].p0};
  end
  for (genvar l = 0; l < INV_LANES; l++) begin : g_lane
    assign lane_idx[l] = ptr_q + IDX_W'(l);
    tlb_match u_match (.entry(ent_q[lane_idx[l]].key), .vppn(vppn_q), .asid(asid_q), .op(op_q),
                       .search_hit(lane_hit_unused[l]), .inv_clr(lane_clr[l]));
  end
  // the write is applied last so it wins over a same-cycle sweep clear
  always_comb begin
    ent_d = ent_q;
    for (int l = 0; l < INV_LANES; l++) if (state_q == SWEEP && lane_clr[l]) ent_d[lane_idx[l]].key.e = 1'b0;
    if (bus.we) ent_d[bus.w_index] = w_ent;
  end
  always_comb begin
    free_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) free_idx = e_vec[i] ? free_idx : IDX_W'(i);
  end
  assign bus.fill_index = &e_vec ? rr_q : free_idx;
  assign rr_d = bus.we && bus.w_fill && &e_vec ? rr_q + 1'b1 : rr_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    op_d = op_q;
    asid_d = asid_q;
    vppn_d = vppn_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.inv_req) begin
        err_d = bus.inv_op > INV_GASID_VA;
        state_d = err_d ? DONE : SWEEP;
        ptr_d = '0;
        op_d = bus.inv_op;
        asid_d = bus.inv_asid;
        vppn_d = bus.inv_vppn;
      end
      SWEEP: begin
        ptr_d = ptr_q + IDX_W'(INV_LANES);
        state_d = ptr_q == IDX_W'(TLBNUM - INV_LANES) ? DONE : SWEEP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) ent_q[i].key.e <= 1'b0;
      rr_q <= '0;
      state_q <= IDLE;
      ptr_q <= '0;
      op_q <= '0;
      asid_q <= '0;
      vppn_q <= '0;
      err_q <= 1'b0;
      valid_q <= '0;
      idx_q <= '0;
      rsp_q <= '0;
    end else begin
      ent_q <= ent_d;
      rr_q <= rr_d;
      state_q <= state_d;
      ptr_q <= ptr_d;
      op_q <= op_d;
      asid_q <= asid_d;
      vppn_q <= vppn_d;
      err_q <= err_d;
      valid_q <= valid_d;
      idx_q <= idx_d;
      rsp_q <= rsp_d;
    end
  assign bus.inv_busy = state_q == SWEEP;
  assign bus.inv_done = state_q == DONE;
  assign bus.inv_err = state_q == DONE && err_q;
  assign {bus.s1_rsp_valid, bus.s0_rsp_valid} = valid_q;
  assign bus.s0_index = idx_q[0];
  assign bus.s1_index = idx_q[1];
  assign {bus.s0_found, bus.s0_ps, bus.s0_ppn, bus.s0_plv, bus.s0_mat, bus.s0_d, bus.s0_v} = rsp_q[0];
  assign {bus.s1_found, bus.s1_ps, bus.s1_ppn, bus.s1_plv, bus.s1_mat, bus.s1_d, bus.s1_v} = rsp_q[1];
  assign r_ent = ent_q[bus.r_index];
  assign {bus.r_e, bus.r_vppn} = {r_ent.key.e, r_ent.key.vppn};
  assign bus.r_ps = r_ent.key.ps4m ? PS_4M : PS_4K;
  assign {bus.r_asid, bus.r_g} = {r_ent.key.asid, r_ent.key.g};
  assign {bus.r_ppn0, bus.r_plv0, bus.r_mat0, bus.r_d0, bus.r_v0} = r_ent.p0;
  assign {bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1, bus.r_v1} = r_ent.p1;
`ifdef TLB_PERF_CNT_EN
  logic [1:0][31:0] hit_q, hit_d, miss_q, miss_d;
  always_comb
    for (int p = 0; p < 2; p++) begin
      hit_d[p] = hit_q[p] + 32'(valid_d[p] && rsp_d[p].found && ~&hit_q[p]);
      miss_d[p] = miss_q[p] + 32'(valid_d[p] && !rsp_d[p].found && ~&miss_q[p]);
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  assign {bus.s1_hit_cnt, bus.s0_hit_cnt} = hit_q;
  assign {bus.s1_miss_cnt, bus.s0_miss_cnt} = miss_q;
`endif
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed checks of search, fill selection, INVTLB sweep and reset for tlb_unit
module tb_tlb_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc, busy, dones;
  tlb_if #(.IDX_W(4)) bus();
  tlb_unit #(.TLBNUM(16), .INV_LANES(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                    input logic [9:0] asid, input logic g, input logic [19:0] ppn1, input logic fill);
    bus.we = 1'b1;
    bus.w_fill = fill;
    bus.w_index = 4'(idx);
    bus.w_e = e;
    bus.w_vppn = vppn;
    bus.w_ps = ps;
    bus.w_asid = asid;
    bus.w_g = g;
    bus.w_ppn0 = ppn1 ^ 20'hFFFFF;
    bus.w_ppn1 = ppn1;
    step();
    bus.we = 1'b0;
    bus.w_fill = 1'b0;
  endtask

  task automatic srch(input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                      input logic [18:0] v1, input logic b1, input logic [9:0] a1);
    bus.s0_req = 1'b1;
    bus.s0_vppn = v0;
    bus.s0_va_bit12 = b0;
    bus.s0_asid = a0;
    bus.s1_req = 1'b1;
    bus.s1_vppn = v1;
    bus.s1_va_bit12 = b1;
    bus.s1_asid = a1;
    step();
    bus.s0_req = 1'b0;
    bus.s1_req = 1'b0;
  endtask

  task automatic rd(input int idx);
    bus.r_index = 4'(idx);
    #1;
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                     output int n, output int b);
    bus.inv_req = 1'b1;
    bus.inv_op = op;
    bus.inv_asid = asid;
    bus.inv_vppn = vppn;
    n = 0;
    b = 0;
    do begin
      step();
      bus.inv_req = 1'b0;
      n++;
      b += int'(bus.inv_busy);
    end while (!bus.inv_done && n < 20);
  endtask

  initial begin
    {bus.s0_req, bus.s1_req, bus.s0_va_bit12, bus.s1_va_bit12} = '0;
    {bus.s0_vppn, bus.s1_vppn, bus.s0_asid, bus.s1_asid} = '0;
    {bus.we, bus.w_fill, bus.w_index, bus.w_e, bus.w_vppn, bus.w_ps, bus.w_asid, bus.w_g} = '0;
    {bus.w_ppn0, bus.w_ppn1, bus.r_index} = '0;
    {bus.w_plv0, bus.w_mat0, bus.w_d0, bus.w_v0} = {2'd0, 2'd1, 1'b0, 1'b1};
    {bus.w_plv1, bus.w_mat1, bus.w_d1, bus.w_v1} = {2'd3, 2'd2, 1'b1, 1'b1};
    {bus.inv_req, bus.inv_op, bus.inv_asid, bus.inv_vppn} = '0;
    step();
    step();
    check("rst_s0_valid", bus.s0_rsp_valid, 0);
    check("rst_s1_found", bus.s1_found, 0);
    check("rst_busy", bus.inv_busy, 0);
    check("rst_done_err", {bus.inv_done, bus.inv_err}, 0);
    check("rst_fill", bus.fill_index, 0);
    rd(0);
    check("rst_r_e", bus.r_e, 0);
    resetn = 1'b1;
    step();
    // 4K entry, odd page via VA[12]
    wr(3, 1, 19'h12345, 6'd12, 10'd5, 0, 20'hABCDE, 0);
    srch(19'h0, 0, 10'd0, 19'h12345, 1, 10'd5);
    check("s1_valid", bus.s1_rsp_valid, 1);
    check("s1_found", bus.s1_found, 1);
    check("s1_index", bus.s1_index, 3);
    check("s1_ppn", bus.s1_ppn, 20'hABCDE);
    check("s1_ps", bus.s1_ps, 12);
    check("s1_plv", bus.s1_plv, 3);
    check("s0_valid", bus.s0_rsp_valid, 1);
    check("s0_miss", bus.s0_found, 0);
    step();
    check("s1_valid_drop", bus.s1_rsp_valid, 0);
    check("s1_index_hold", bus.s1_index, 3);
    srch(19'h12345, 0, 10'd5, 19'h12345, 1, 10'd6);
    check("s0_even_ppn", bus.s0_ppn, 20'h54321);
    check("s0_even_mat", bus.s0_mat, 1);
    check("s1_asid_miss", bus.s1_found, 0);
    // 4M global entry: odd page chosen by vppn[8]
    wr(7, 1, 19'h40000, 6'd21, 10'd0, 1, 20'h33333, 0);
    srch(19'h401FF, 0, 10'd9, 19'h40000, 1, 10'h3FF);
    check("s0_4m_found", bus.s0_found, 1);
    check("s0_4m_index", bus.s0_index, 7);
    check("s0_4m_ppn", bus.s0_ppn, 20'h33333);
    check("s0_4m_ps", bus.s0_ps, 21);
    check("s1_4m_even_ppn", bus.s1_ppn, 20'hCCCCC);
    // duplicate match -> lowest index
    wr(9, 1, 19'h00AAA, 6'd12, 10'd1, 0, 20'h99999, 0);
    wr(2, 1, 19'h00AAA, 6'd12, 10'd1, 0, 20'h22222, 0);
    srch(19'h00AAA, 1, 10'd1, 19'h00AAA, 0, 10'd1);
    check("dup_s0_index", bus.s0_index, 2);
    check("dup_s0_ppn", bus.s0_ppn, 20'h22222);
    check("dup_s1_ppn", bus.s1_ppn, 20'hDDDDD);
    rd(9);
    check("rd9_vppn", bus.r_vppn, 19'h00AAA);
    check("rd9_ps", bus.r_ps, 12);
    rd(7);
    check("rd7_ps", bus.r_ps, 21);
    check("rd7_g", bus.r_g, 1);
    // fill selection
    check("fill_free0", bus.fill_index, 0);
    for (int i = 0; i < 16; i++)
      if (!(i inside {2, 3, 7, 9})) wr(i, 1, 19'(32'h70000 + i), 6'd12, 10'h3FF, 0, 20'(i), 0);
    check("fill_full_rr0", bus.fill_index, 0);
    wr(12, 1, 19'h7000C, 6'd12, 10'h3FF, 0, 20'd12, 1);
    check("fill_rr1", bus.fill_index, 1);
    for (int k = 0; k < 3; k++) wr(12, 1, 19'h7000C, 6'd12, 10'h3FF, 0, 20'd12, 1);
    check("fill_rr4", bus.fill_index, 4);
    wr(5, 0, 19'h70005, 6'd12, 10'h3FF, 0, 20'd5, 0);
    check("fill_free5", bus.fill_index, 5);
    // INVTLB op 4
    inv(5'd4, 10'd5, 19'h0, cyc, busy);
    check("op4_latency", cyc, 5);
    check("op4_busy_cycles", busy, 4);
    check("op4_err", bus.inv_err, 0);
    rd(3);
    check("op4_e3", bus.r_e, 0);
    rd(7);
    check("op4_e7", bus.r_e, 1);
    check("op4_fill3", bus.fill_index, 3);
    step();
    check("op4_done_pulse", bus.inv_done, 0);
    // illegal op
    inv(5'd9, 10'd0, 19'h0, cyc, busy);
    check("op9_latency", cyc, 1);
    check("op9_err", bus.inv_err, 1);
    check("op9_busy", busy, 0);
    rd(7);
    check("op9_e7", bus.r_e, 1);
    step();
    // op 6 and op 2
    inv(5'd6, 10'h3FF, 19'h7000A, cyc, busy);
    rd(10);
    check("op6_e10", bus.r_e, 0);
    rd(11);
    check("op6_e11", bus.r_e, 1);
    step();
    inv(5'd2, 10'd0, 19'h0, cyc, busy);
    rd(7);
    check("op2_e7", bus.r_e, 0);
    rd(2);
    check("op2_e2", bus.r_e, 1);
    step();
    // write beats a same-cycle sweep clear of its group
    bus.inv_req = 1'b1;
    bus.inv_op = 5'd0;
    step();
    bus.inv_req = 1'b0;
    wr(3, 1, 19'h55555, 6'd12, 10'd5, 0, 20'h12121, 0);
    cyc = 0;
    while (!bus.inv_done && cyc < 10) begin
      step();
      cyc++;
    end
    check("op0_done_seen", bus.inv_done, 1);
    rd(3);
    check("wprio_e3", bus.r_e, 1);
    check("wprio_vppn3", bus.r_vppn, 19'h55555);
    rd(4);
    check("op0_e4", bus.r_e, 0);
    step();
    srch(19'h55555, 1, 10'd5, 19'h0, 0, 10'd0);
    check("wprio_search", {bus.s0_found, bus.s0_index}, {1'b1, 4'd3});
    // reset mid-sweep
    bus.inv_req = 1'b1;
    bus.inv_op = 5'd3;
    step();
    bus.inv_req = 1'b0;
    step();
    check("midrst_busy_pre", bus.inv_busy, 1);
    resetn = 1'b0;
    rd(3);
    check("midrst_busy", bus.inv_busy, 0);
    check("midrst_e3", bus.r_e, 0);
    check("midrst_fill", bus.fill_index, 0);
    step();
    resetn = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      dones += int'(bus.inv_done);
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", bus.inv_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
Parametrised successor to the 16-entry fully-associative LoongArch TLB. It keeps two search ports (fetch, load/store), a write port and a read port, and adds:
- a registered one-cycle search pipeline;
- hardware fill-index selection (first free entry, else round-robin);
- a multi-cycle INVTLB sweep engine with a busy/done handshake and page-size-aware VPPN compare.

It sits between the CSR/TLB-instruction logic and the IF/MEM address-translation stages.

Parameters:
TLBNUM, 16, number of entries; power of two, 4..64.
INV_LANES, 4, entries examined per sweep cycle; must divide TLBNUM.
IDX_W, $clog2(TLBNUM), index width (derived; do not override).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
s0_req, s1_req  in  1  search request, sampled at posedge
s0_vppn, s1_vppn  in  19  VA[31:13]
s0_va_bit12, s1_va_bit12  in  1  VA[12]
s0_asid, s1_asid  in  10  ASID
s0_rsp_valid, s1_rsp_valid  out  1  result valid, one cycle after req
s0_found/s1_found  out  1; s*_index  out  IDX_W; s*_ppn  out  20; s*_ps  out  6; s*_plv  out  2; s*_mat  out  2; s*_d  out  1; s*_v  out  1
we  in  1  write enable
w_index  in  IDX_W  entry to write
w_fill  in  1  write is a TLBFILL (advances replacement pointer)
w_e, w_vppn[19], w_ps[6], w_asid[10], w_g, w_ppn0[20], w_plv0[2], w_mat0[2], w_d0, w_v0, w_ppn1[20], w_plv1[2], w_mat1[2], w_d1, w_v1  in  entry fields
r_index  in  IDX_W; r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  out  combinational read
fill_index  out  IDX_W  suggested TLBFILL target
inv_req  in  1  start INVTLB
inv_op  in  5  INVTLB op
inv_asid  in  10  ASID operand
inv_vppn  in  19  VA operand [31:13]
inv_busy  out  1  sweep in progress
inv_done  out  1  one-cycle completion pulse
inv_err  out  1  valid with inv_done; op > 6

Behaviour:
- Reset (async, resetn=0):
  - all e bits = 0; rr_ptr = 0; FSM = IDLE.
  - All s* outputs, s*_rsp_valid, inv_busy, inv_done and inv_err = 0.
  - Other entry fields are not reset.
  - Reset mid-sweep aborts the sweep; no done pulse is produced.
- Entry storage: ps is stored as 1 bit (1 iff w_ps==21, otherwise 4 KB). r_ps and s*_ps return 21 or 12.
- Search, latency 1:
  - At the posedge where s*_req=1, compute the match set. An entry matches when all hold: e; vppn[18:9] equal; (4M or vppn[8:0] equal); (asid equal or g).
  - Lowest matching index wins.
  - Odd-page select = 4M ? vppn[8] : va_bit12.
  - Results are registered. rsp_valid=1 the next cycle; outputs hold until the next req. rsp_valid=0 on cycles without a req.
  - Search sees pre-edge contents: a same-cycle write or clear is not visible.
- Write: on posedge when we=1, update entry w_index. Write has priority over a sweep clear of the same entry in the same cycle. Writes are accepted while inv_busy.
- Fill: fill_index is combinational.
  - If any e=0, fill_index = lowest invalid index; otherwise rr_ptr.
  - rr_ptr increments (wraps TLBNUM-1 -> 0) on we && w_fill when all entries are valid.
- INVTLB FSM, states IDLE / SWEEP / DONE:
  - IDLE: inv_req with op<=6 latches op, asid and vppn, sets ptr=0, goes to SWEEP. inv_req with op>6 goes to DONE with err=1.
  - SWEEP: inv_busy=1. Each cycle evaluates entries ptr..ptr+INV_LANES-1 and clears e where the condition holds. ptr += INV_LANES. After the last group, go to DONE.
  - DONE: inv_done=1 (inv_err per op) for one cycle, then IDLE.
  - inv_req is ignored unless in IDLE.
  - Request-to-done latency = TLBNUM/INV_LANES + 1 cycles.
- Clear conditions:
  - op 0, 1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 & asid equal.
  - op 5: g=0 & asid equal & va match.
  - op 6: (g | asid equal) & va match.
  - va match uses the stored page size: 4M compares vppn[18:9] only.
- Searches during a sweep use current e bits. The core stalls on inv_busy.

Optional Feature:
TLB_PERF_CNT_EN:
- Defined: adds outputs s0_hit_cnt, s0_miss_cnt, s1_hit_cnt and s1_miss_cnt (32-bit, saturating). Each increments when rsp_valid is produced with found=1 / found=0. All reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package tlb_pkg: INVTLB op localparams (INV_ALL0, INV_ALL1, INV_G, INV_NG, INV_ASID, INV_ASID_VA, INV_GASID_VA), PS_4K=12, PS_4M=21, FSM state encoding, packed entry typedef.
- Sub-module tlb_match: one-entry compare. Inputs: entry, vppn, asid, op. Outputs: search_hit and inv_clr. Instantiated TLBNUM times (search) plus INV_LANES times (sweep).

Test Plan:
- Write idx 3 (vppn=0x12345, asid=5, g=0, ps=12, ppn1=0xABCDE); search s1 with vppn=0x12345, asid=5, bit12=1 -> next cycle rsp_valid=1, found=1, index=3, ppn=0xABCDE, ps=12.
- Write idx 7 with ps=21, vppn=0x40000, g=1; search vppn=0x401FF, asid=9, bit12=0 -> found=1, index=7, odd page selected (vppn[8]=1).
- Same vppn/asid written to idx 2 and idx 9 -> search returns index=2.
- All 16 entries valid, TLBNUM=16, INV_LANES=4 -> fill_index=rr_ptr=0. Four we&w_fill writes -> rr_ptr=4. Clear idx 5 -> fill_index=5.
- inv_req op=4, asid=5 with entries 3 (g=0, asid=5) and 7 (g=1) valid -> inv_busy for 4 cycles, inv_done at cycle 5; entry 3 e=0, entry 7 e=1. Op=9 -> done after 1 cycle with inv_err=1, no change.
- Sweep in progress, we to entry 3 in the same cycle its group clears -> entry 3 holds the new write. Deassert resetn mid-sweep -> all e=0, inv_busy=0, no inv_done.
